// File: rtl/hopfield_pkg.sv
// Shared types and constants for the Hopfield frame loader.
// Noise injection is gated by HOPFIELD_LOADER_NOISE_EN.
package hopfield_pkg;

    localparam int DEF_MEM_WIDTH   = 16;
    localparam int DEF_IMAGE_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE
    } loader_state_e;

    localparam int BIPOLAR_POS = 1;
    localparam int BIPOLAR_NEG = -1;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/hopfield_noise_lfsr.sv
// 16-bit Galois LFSR used to corrupt recall frames.
// Only instantiated when HOPFIELD_LOADER_NOISE_EN is defined.
module hopfield_noise_lfsr
    import hopfield_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else if (adv) begin
            state <= {1'b0, state[15:1]}
                   ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/hopfield_frame_loader.sv
// Pixel stream to double-buffered bipolar image for the Hopfield core.
// Define HOPFIELD_LOADER_NOISE_EN to flip recall pixels from an LFSR.
module hopfield_frame_loader
    import hopfield_pkg::*;
#(
    parameter int MEM_WIDTH   = DEF_MEM_WIDTH,
    parameter int IMAGE_WIDTH = DEF_IMAGE_WIDTH,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PIXEL_WIDTH-1:0] s_pixel,
    input  logic                   s_last,
    input  logic                   s_mode,
    input  logic [PIXEL_WIDTH-1:0] threshold,
    output logic [MEM_WIDTH*IMAGE_WIDTH*IMAGE_WIDTH-1:0] image,
    output logic                   fit,
    output logic                   img_valid,
    output logic                   frame_err
);

    localparam int N  = IMAGE_WIDTH * IMAGE_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [MEM_WIDTH-1:0] W_POS = MEM_WIDTH'(BIPOLAR_POS);
    localparam logic [MEM_WIDTH-1:0] W_NEG = MEM_WIDTH'(BIPOLAR_NEG);

    loader_state_e          state;
    logic [IW-1:0]          idx;
    logic [N-1:0]           shadow;
    logic [N-1:0]           merged;
    logic                   mode_q;
    logic [PIXEL_WIDTH-1:0] thr_q;

    logic                   beat;
    logic                   first;
    logic                   at_last;
    logic                   neg;
    logic                   flip;
    logic [PIXEL_WIDTH-1:0] thr_eff;

    assign beat    = s_valid && s_ready;
    assign first   = (state == IDLE);
    assign at_last = (idx == LAST);
    // The first beat binarizes against the live threshold
    assign thr_eff = first ? threshold : thr_q;

`ifdef HOPFIELD_LOADER_NOISE_EN
    logic [15:0] lfsr;
    logic        mode_eff;

    assign mode_eff = first ? s_mode : mode_q;

    hopfield_noise_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (beat),
        .state (lfsr)
    );

    assign flip = !mode_eff && (lfsr[3:0] == 4'd0);
`else
    assign flip = 1'b0;
`endif

    assign neg = (s_pixel < thr_eff) ^ flip;

    // Shadow holds sign bits; the final pixel merges in on publish
    always_comb begin
        merged      = shadow;
        merged[idx] = neg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            shadow    <= '0;
            image     <= '0;
            mode_q    <= 1'b0;
            thr_q     <= '0;
            fit       <= 1'b0;
            img_valid <= 1'b0;
            frame_err <= 1'b0;
            s_ready   <= 1'b1;
        end else begin
            fit       <= 1'b0;
            img_valid <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE, LOAD: begin
                    if (beat) begin
                        if (first) begin
                            mode_q <= s_mode;
                            thr_q  <= threshold;
                        end
                        unique case (1'b1)
                            at_last && s_last: begin
                                for (int k = 0; k < N; k++) begin
                                    image[MEM_WIDTH*k +: MEM_WIDTH] <=
                                        merged[k] ? W_NEG : W_POS;
                                end
                                fit       <= mode_q;
                                img_valid <= 1'b1;
                                idx       <= '0;
                                s_ready   <= 1'b0;
                                state     <= ISSUE;
                            end
                            at_last != s_last: begin
                                frame_err <= 1'b1;
                                idx       <= '0;
                                state     <= IDLE;
                            end
                            default: begin
                                shadow <= merged;
                                idx    <= idx + 1'b1;
                                state  <= LOAD;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    s_ready <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    s_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hopfield_frame_loader.sv
// Randomized self-checking bench for hopfield_frame_loader.
// Uses a 2x2 image; noise model follows HOPFIELD_LOADER_NOISE_EN.
module tb_hopfield_frame_loader;

    localparam int MW = 16;
    localparam int IMW = 2;
    localparam int N = IMW * IMW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    s_pixel = '0;
    logic          s_last = 1'b0;
    logic          s_mode = 1'b0;
    logic [7:0]    threshold = '0;
    logic [MW*N-1:0] image;
    logic          fit;
    logic          img_valid;
    logic          frame_err;

    int tests = 0;
    int fails = 0;
    logic [MW*N-1:0] cur_img = '0;
    logic [15:0]     mlfsr = 16'hACE1;
    logic [7:0]      fpix [N];

    hopfield_frame_loader #(
        .MEM_WIDTH   (MW),
        .IMAGE_WIDTH (IMW),
        .PIXEL_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_pixel   (s_pixel),
        .s_last    (s_last),
        .s_mode    (s_mode),
        .threshold (threshold),
        .image     (image),
        .fit       (fit),
        .img_valid (img_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // One accepted beat; returns the model's sign bit (1 = -1)
    task automatic send_beat(input logic [7:0] pix, input logic last,
                             input logic dmode, input logic [7:0] dthr,
                             input logic fmode, input logic [7:0] fthr,
                             output logic negb);
        int n;
        @(negedge clk);
        s_valid = 1'b1;
        s_pixel = pix;
        s_last = last;
        s_mode = dmode;
        threshold = dthr;
        n = 0;
        while (!s_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL beat_wait ready=%b required 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        negb = (pix < fthr);
`ifdef HOPFIELD_LOADER_NOISE_EN
        if (!fmode && mlfsr[3:0] == 4'd0) negb = !negb;
        mlfsr = {1'b0, mlfsr[15:1]} ^ (mlfsr[0] ? 16'hB400 : 16'h0);
`else
        if (fmode === 1'bx) negb = 1'bx;
`endif
    endtask

    task automatic run_frame(input logic md, input logic [7:0] thr,
                             input int gapmax);
        logic nb;
        logic [MW*N-1:0] exp_img;
        exp_img = '0;
        for (int k = 0; k < N; k++) begin
            repeat ($urandom_range(0, gapmax)) begin
                @(negedge clk);
                tests++;
                if (s_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL gap_ready got=%b required 1", s_ready);
                end
            end
            send_beat(fpix[k], k == N - 1,
                      (k == 0) ? md : 1'($urandom),
                      (k == 0) ? thr : 8'($urandom),
                      md, thr, nb);
            exp_img[MW*k +: MW] = nb ? 16'hFFFF : 16'h0001;
            if (k < N - 1) begin
                tests++;
                if ({img_valid, frame_err} !== 2'b00) begin
                    fails++;
                    $display("FAIL mid_beat vld/err=%b%b required 00",
                             img_valid, frame_err);
                end
            end
        end
        tests++;
        if (image !== exp_img) begin
            fails++;
            $display("FAIL publish_image got=%h required %h",
                     image, exp_img);
        end
        tests++;
        if ({img_valid, fit, s_ready, frame_err} !== {1'b1, md, 2'b00}) begin
            fails++;
            $display("FAIL issue_flags vld,fit,rdy,err=%b%b%b%b required 1%b00",
                     img_valid, fit, s_ready, frame_err, md);
        end
        @(posedge clk);
        #1;
        tests++;
        if ({img_valid, fit, s_ready, frame_err} !== 4'b0010
            || image !== exp_img) begin
            fails++;
            $display("FAIL after_issue vld,fit,rdy,err=%b%b%b%b img=%h required 0010 img=%h",
                     img_valid, fit, s_ready, frame_err, image, exp_img);
        end
        cur_img = exp_img;
    endtask

    task automatic err_frame(input int stop, input logic lastflag);
        logic nb;
        for (int k = 0; k <= stop; k++) begin
            send_beat(8'($urandom), (k == stop) ? lastflag : 1'b0,
                      1'b0, 8'd128, 1'b0, 8'd128, nb);
        end
        tests++;
        if ({frame_err, img_valid, fit, s_ready} !== 4'b1001
            || image !== cur_img) begin
            fails++;
            $display("FAIL err_pulse err,vld,fit,rdy=%b%b%b%b img=%h required 1001 img=%h",
                     frame_err, img_valid, fit, s_ready, image, cur_img);
        end
        @(posedge clk);
        #1;
        tests++;
        if (frame_err !== 1'b0) begin
            fails++;
            $display("FAIL err_width err=%b required 0", frame_err);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        mlfsr = 16'hACE1;
        cur_img = '0;
        tests++;
        if ({image, fit, img_valid, frame_err, s_ready}
            !== {{(MW*N){1'b0}}, 4'b0001}) begin
            fails++;
            $display("FAIL reset_state img=%h fit,vld,err,rdy=%b%b%b%b required 0 0001",
                     image, fit, img_valid, frame_err, s_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_train();
        fpix[0] = 8'd200;
        fpix[1] = 8'd10;
        fpix[2] = 8'd128;
        fpix[3] = 8'd127;
        run_frame(1'b1, 8'd128, 0);
        tests++;
        if (cur_img !== 64'hFFFF_0001_FFFF_0001) begin
            fails++;
            $display("FAIL train_const got=%h required FFFF0001FFFF0001",
                     cur_img);
        end
    endtask

    task automatic test_recall_hold();
        run_frame(1'b0, 8'd128, 0);
        repeat (50) begin
            @(posedge clk);
            #1;
            tests++;
            if (image !== cur_img || img_valid !== 1'b0) begin
                fails++;
                $display("FAIL hold img=%h vld=%b required %h 0",
                         image, img_valid, cur_img);
            end
        end
    endtask

    task automatic test_framing();
        err_frame(1, 1'b1);
        for (int k = 0; k < N; k++) fpix[k] = 8'($urandom);
        run_frame(1'b1, 8'($urandom), 0);
        err_frame(0, 1'b1);
        err_frame(N - 1, 1'b0);
        for (int k = 0; k < N; k++) fpix[k] = 8'($urandom);
        run_frame(1'b0, 8'($urandom), 1);
    endtask

    task automatic test_reset_mid();
        logic nb;
        send_beat(8'd1, 1'b0, 1'b1, 8'd9, 1'b1, 8'd9, nb);
        send_beat(8'd99, 1'b0, 1'b1, 8'd9, 1'b1, 8'd9, nb);
        apply_reset();
        for (int k = 0; k < N; k++) fpix[k] = 8'($urandom);
        run_frame(1'b1, 8'($urandom), 0);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) fpix[k] = 8'($urandom);
            run_frame(1'($urandom), 8'($urandom), 3);
        end
    endtask

    task automatic test_noise_frames();
        for (int f = 0; f < 25; f++) begin
            for (int k = 0; k < N; k++) fpix[k] = 8'($urandom);
            run_frame(1'b0, 8'($urandom), 0);
        end
        for (int k = 0; k < N; k++) fpix[k] = 8'($urandom);
        run_frame(1'b1, 8'($urandom), 0);
    endtask

    initial begin
        test_reset();
        test_train();
        test_recall_hold();
        test_framing();
        test_reset_mid();
        test_back_to_back();
        test_noise_frames();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
